// File: rtl/conv_window_tracker_pkg.sv
// rtl/conv_window_tracker_pkg.sv - conv_pkg: tracker FSM states, width helpers, fill threshold
package conv_pkg;

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  // Counters always keep at least one bit, even for a single-value range.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int col_width(input int img_w);
    return cnt_width(img_w);
  endfunction

  function automatic int row_width(input int img_h);
    return cnt_width(img_h);
  endfunction

  function automatic int pix_width(input int img_w, input int img_h);
    return cnt_width(img_w * img_h + 1);
  endfunction

  // Index of the first pixel that completes a K x K window.
  function automatic int fill_thresh(input int k, input int img_w);
    return (k - 1) * img_w + k - 1;
  endfunction

endpackage

// File: rtl/conv_window_tracker_wrap_counter.sv
// rtl/conv_window_tracker_wrap_counter.sv - modulo-MAX counter with clear priority and wrap flag
module wrap_counter #(
  parameter int MAX = 2,
  parameter int W   = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Clr,
  input  logic         Inc,
  output logic [W-1:0] value,
  output logic         Wrap
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  assign Wrap = Inc & (value == LAST);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)
      value <= '0;
    else if (Clr)
      value <= '0;
    else if (Inc)
      value <= Wrap ? '0 : value + 1'b1;
  end

endmodule

// File: rtl/conv_window_tracker.sv
// rtl/conv_window_tracker.sv - K x K window validity tracker for a raster pixel stream
// Optional stride decimation enabled by defining CONV_TRACK_STRIDE_EN.
module conv_window_tracker
  import conv_pkg::*;
#(
  parameter int IMG_W  = 100,
  parameter int IMG_H  = 101,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  localparam int COL_W = col_width(IMG_W),
  localparam int ROW_W = row_width(IMG_H),
  localparam int PIX_W = pix_width(IMG_W, IMG_H)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             En,
  output logic             Win_Valid,
  output logic             Fill_Done,
  output logic             Frame_Done,
  output logic             Busy,
  output logic [COL_W-1:0] Col,
  output logic [ROW_W-1:0] Row,
  output logic [PIX_W-1:0] Pix_Cnt
);

  localparam logic [PIX_W-1:0] PIX_MAX  = PIX_W'(IMG_W * IMG_H);
  localparam logic [PIX_W-1:0] FILL_CNT = PIX_W'(fill_thresh(K, IMG_W));
  localparam logic [COL_W-1:0] K_COL    = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] K_ROW    = ROW_W'(K - 1);

  state_t state, state_nxt;
  logic   accept, col_wrap, row_wrap, stride_ok, qualify, fill_hit;

  // Start wins over En so a restart never counts the pixel offered with it.
  assign accept = En & ~Start & ((state == FILL) | (state == RUN));

  wrap_counter #(.MAX(IMG_W), .W(COL_W)) u_col (
    .Clk(Clk), .Rst(Rst), .Clr(Start), .Inc(accept), .value(Col), .Wrap(col_wrap)
  );

  wrap_counter #(.MAX(IMG_H), .W(ROW_W)) u_row (
    .Clk(Clk), .Rst(Rst), .Clr(Start), .Inc(col_wrap), .value(Row), .Wrap(row_wrap)
  );

`ifdef CONV_TRACK_STRIDE_EN
  localparam int PH_W = cnt_width(STRIDE);

  logic [PH_W-1:0] col_ph, row_ph;
  logic            col_ph_wrap_unused, row_ph_wrap_unused;

  // Phases start counting at the first window column/row so that one is always sampled.
  wrap_counter #(.MAX(STRIDE), .W(PH_W)) u_col_ph (
    .Clk(Clk), .Rst(Rst), .Clr(Start | col_wrap), .Inc(accept & (Col >= K_COL)),
    .value(col_ph), .Wrap(col_ph_wrap_unused)
  );

  wrap_counter #(.MAX(STRIDE), .W(PH_W)) u_row_ph (
    .Clk(Clk), .Rst(Rst), .Clr(Start), .Inc(col_wrap & (Row >= K_ROW)),
    .value(row_ph), .Wrap(row_ph_wrap_unused)
  );

  assign stride_ok = (col_ph == '0) & (row_ph == '0);
`else
  localparam int stride_unused = STRIDE;

  assign stride_ok = 1'b1;
`endif

  assign qualify  = accept & (Row >= K_ROW) & (Col >= K_COL) & stride_ok;
  assign fill_hit = accept & (Pix_Cnt == FILL_CNT);
  assign Busy     = (state == FILL) | (state == RUN);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= IDLE;
      Pix_Cnt    <= '0;
      Win_Valid  <= 1'b0;
      Frame_Done <= 1'b0;
      Fill_Done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      Win_Valid  <= qualify;
      Frame_Done <= accept & row_wrap;
      if (Start)
        Pix_Cnt <= '0;
      else if (accept && (Pix_Cnt != PIX_MAX))
        Pix_Cnt <= Pix_Cnt + 1'b1;
      if (Start)
        Fill_Done <= 1'b0;
      else if (fill_hit)
        Fill_Done <= 1'b1;
    end
  end

  // row_wrap only fires on an accepted last-column pixel of the last row.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (Start) state_nxt = FILL;
      FILL: begin
        if (Start)
          state_nxt = FILL;
        else if (row_wrap)
          state_nxt = DONE;
        else if (fill_hit)
          state_nxt = RUN;
      end
      RUN: begin
        if (Start)
          state_nxt = FILL;
        else if (row_wrap)
          state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_window_tracker.sv
// tb/tb_conv_window_tracker.sv - scoreboard bench for conv_window_tracker (8x6 K=3 and 4x2 K=1)
module tb_conv_window_tracker;

`ifdef CONV_TRACK_STRIDE_EN
  localparam int S_A       = 2;
  localparam int EXP_PULSE = 6;
`else
  localparam int S_A       = 1;
  localparam int EXP_PULSE = 24;
`endif

  localparam int CW[2] = '{8, 4};
  localparam int CH[2] = '{6, 2};
  localparam int CK[2] = '{3, 1};
  localparam int CS[2] = '{S_A, 1};

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Rst = 1'b0;
  logic st_a = 1'b0, en_a = 1'b0, st_b = 1'b0, en_b = 1'b0;
  logic wv_a, fill_a, fd_a, busy_a, wv_b, fill_b, fd_b, busy_b;
  logic [2:0] col_a, row_a;
  logic [5:0] pix_a;
  logic [1:0] col_b;
  logic [0:0] row_b;
  logic [3:0] pix_b;

  conv_window_tracker #(.IMG_W(8), .IMG_H(6), .K(3), .STRIDE(2)) dut_a (
    .Clk(Clk), .Rst(Rst), .Start(st_a), .En(en_a), .Win_Valid(wv_a), .Fill_Done(fill_a),
    .Frame_Done(fd_a), .Busy(busy_a), .Col(col_a), .Row(row_a), .Pix_Cnt(pix_a)
  );

  conv_window_tracker #(.IMG_W(4), .IMG_H(2), .K(1), .STRIDE(1)) dut_b (
    .Clk(Clk), .Rst(Rst), .Start(st_b), .En(en_b), .Win_Valid(wv_b), .Fill_Done(fill_b),
    .Frame_Done(fd_b), .Busy(busy_b), .Col(col_b), .Row(row_b), .Pix_Cnt(pix_b)
  );

  typedef struct {
    int sel;
    bit wv;
    bit fd;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_err = 0;
  int   pulses, first_idx;
  int   m_r[2], m_c[2], m_cnt[2];
  bit   m_act[2], m_fill[2];

  task automatic model_clear();
    for (int s = 0; s < 2; s++) begin
      m_r[s] = 0; m_c[s] = 0; m_cnt[s] = 0; m_act[s] = 0; m_fill[s] = 0;
    end
  endtask

  task automatic cycle(input int sel, input bit en, input bit st);
    exp_t e;
    int   o_wv, o_fd, o_fill, o_busy, o_col, o_row, o_pix;
    e.sel = sel; e.wv = 0; e.fd = 0;
    if (st) begin
      m_r[sel] = 0; m_c[sel] = 0; m_cnt[sel] = 0; m_act[sel] = 1; m_fill[sel] = 0;
    end else if (en && m_act[sel]) begin
      e.wv = (m_r[sel] >= CK[sel] - 1) && (m_c[sel] >= CK[sel] - 1) &&
             ((m_r[sel] - (CK[sel] - 1)) % CS[sel] == 0) &&
             ((m_c[sel] - (CK[sel] - 1)) % CS[sel] == 0);
      if (m_cnt[sel] == (CK[sel] - 1) * CW[sel] + CK[sel] - 1) m_fill[sel] = 1;
      if (m_r[sel] == CH[sel] - 1 && m_c[sel] == CW[sel] - 1) begin
        e.fd = 1; m_act[sel] = 0;
      end
      m_cnt[sel]++;
      if (m_c[sel] == CW[sel] - 1) begin
        m_c[sel] = 0;
        m_r[sel] = (m_r[sel] == CH[sel] - 1) ? 0 : m_r[sel] + 1;
      end else begin
        m_c[sel]++;
      end
    end
    sb.push_back(e);
    if (sel == 0) begin en_a = en; st_a = st; end
    else begin en_b = en; st_b = st; end
    @(posedge Clk);
    #1;
    en_a = 0; st_a = 0; en_b = 0; st_b = 0;
    e = sb.pop_front();
    if (e.sel == 0) begin
      o_wv = wv_a; o_fd = fd_a; o_fill = fill_a; o_busy = busy_a;
      o_col = int'(col_a); o_row = int'(row_a); o_pix = int'(pix_a);
    end else begin
      o_wv = wv_b; o_fd = fd_b; o_fill = fill_b; o_busy = busy_b;
      o_col = int'(col_b); o_row = int'(row_b); o_pix = int'(pix_b);
    end
    n_cmp += 7;
    if (o_wv !== int'(e.wv)) begin n_err++; $display("FAIL win_valid dut%0d pix=%0d got=%0d exp=%0d", sel, o_pix, o_wv, e.wv); end
    if (o_fd !== int'(e.fd)) begin n_err++; $display("FAIL frame_done dut%0d got=%0d exp=%0d", sel, o_fd, e.fd); end
    if (o_fill !== int'(m_fill[sel])) begin n_err++; $display("FAIL fill_done dut%0d got=%0d exp=%0d", sel, o_fill, m_fill[sel]); end
    if (o_busy !== int'(m_act[sel])) begin n_err++; $display("FAIL busy dut%0d got=%0d exp=%0d", sel, o_busy, m_act[sel]); end
    if (o_col !== m_c[sel]) begin n_err++; $display("FAIL col dut%0d got=%0d exp=%0d", sel, o_col, m_c[sel]); end
    if (o_row !== m_r[sel]) begin n_err++; $display("FAIL row dut%0d got=%0d exp=%0d", sel, o_row, m_r[sel]); end
    if (o_pix !== m_cnt[sel]) begin n_err++; $display("FAIL pix_cnt dut%0d got=%0d exp=%0d", sel, o_pix, m_cnt[sel]); end
    if (o_wv == 1) begin
      pulses++;
      if (first_idx < 0) first_idx = o_pix - 1;
    end
  endtask

  task automatic test_reset();
    Rst = 0;
    model_clear();
    #12;
    n_cmp += 2;
    if ({wv_a, fill_a, fd_a, busy_a, col_a, row_a, pix_a} !== '0) begin
      n_err++; $display("FAIL reset_a got=%h exp=0", {wv_a, fill_a, fd_a, busy_a, col_a, row_a, pix_a});
    end
    if ({wv_b, fill_b, fd_b, busy_b, col_b, row_b, pix_b} !== '0) begin
      n_err++; $display("FAIL reset_b got=%h exp=0", {wv_b, fill_b, fd_b, busy_b, col_b, row_b, pix_b});
    end
    @(negedge Clk);
    Rst = 1;
  endtask

  task automatic test_full_frame();
    pulses = 0; first_idx = -1;
    cycle(0, 0, 1);
    repeat (48) cycle(0, 1, 0);
    n_cmp += 4;
    if (pulses !== EXP_PULSE) begin n_err++; $display("FAIL full_pulses got=%0d exp=%0d", pulses, EXP_PULSE); end
    if (first_idx !== 18) begin n_err++; $display("FAIL full_first_idx got=%0d exp=18", first_idx); end
    if (pix_a !== 6'd48) begin n_err++; $display("FAIL full_pix got=%0d exp=48", pix_a); end
    if (busy_a !== 1'b0) begin n_err++; $display("FAIL full_busy got=%0d exp=0", busy_a); end
    repeat (2) cycle(0, 1, 0);
  endtask

  task automatic test_en_gaps();
    pulses = 0; first_idx = -1;
    cycle(0, 0, 1);
    for (int i = 0; i < 96; i++) cycle(0, (i % 2) == 0, 0);
    n_cmp += 2;
    if (pulses !== EXP_PULSE) begin n_err++; $display("FAIL gaps_pulses got=%0d exp=%0d", pulses, EXP_PULSE); end
    if (pix_a !== 6'd48) begin n_err++; $display("FAIL gaps_pix got=%0d exp=48", pix_a); end
  endtask

  task automatic test_restart();
    cycle(0, 0, 1);
    repeat (30) cycle(0, 1, 0);
    cycle(0, 1, 1);
    n_cmp += 2;
    if (pix_a !== 6'd0) begin n_err++; $display("FAIL restart_pix got=%0d exp=0", pix_a); end
    if (fill_a !== 1'b0) begin n_err++; $display("FAIL restart_fill got=%0d exp=0", fill_a); end
    pulses = 0; first_idx = -1;
    repeat (48) cycle(0, 1, 0);
    n_cmp += 2;
    if (pulses !== EXP_PULSE) begin n_err++; $display("FAIL restart_pulses got=%0d exp=%0d", pulses, EXP_PULSE); end
    if (first_idx !== 18) begin n_err++; $display("FAIL restart_first_idx got=%0d exp=18", first_idx); end
  endtask

  task automatic test_async_reset();
    cycle(0, 0, 1);
    repeat (20) cycle(0, 1, 0);
    #2 Rst = 0;
    #1;
    n_cmp += 1;
    if ({wv_a, fill_a, fd_a, busy_a, col_a, row_a, pix_a} !== '0) begin
      n_err++; $display("FAIL async_reset got=%h exp=0", {wv_a, fill_a, fd_a, busy_a, col_a, row_a, pix_a});
    end
    model_clear();
    @(negedge Clk);
    Rst = 1;
    repeat (3) cycle(0, 1, 0);
    n_cmp += 2;
    if (pix_a !== 6'd0) begin n_err++; $display("FAIL idle_en_pix got=%0d exp=0", pix_a); end
    if (busy_a !== 1'b0) begin n_err++; $display("FAIL idle_en_busy got=%0d exp=0", busy_a); end
  endtask

  task automatic test_k1();
    pulses = 0; first_idx = -1;
    cycle(1, 0, 1);
    cycle(1, 1, 0);
    n_cmp += 1;
    if (fill_b !== 1'b1) begin n_err++; $display("FAIL k1_fill got=%0d exp=1", fill_b); end
    repeat (7) cycle(1, 1, 0);
    repeat (2) cycle(1, 1, 0);
    n_cmp += 3;
    if (pulses !== 8) begin n_err++; $display("FAIL k1_pulses got=%0d exp=8", pulses); end
    if (first_idx !== 0) begin n_err++; $display("FAIL k1_first_idx got=%0d exp=0", first_idx); end
    if (pix_b !== 4'd8) begin n_err++; $display("FAIL k1_pix got=%0d exp=8", pix_b); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_frame();
    test_en_gaps();
    test_restart();
    test_async_reset();
    test_k1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
